// File: rtl/mp_adder_arbiter.sv
// mp_adder_arbiter: round-robin arbiter that time-shares a single
// multi-precision adder (mp_adder, defined below) between N_REQ requesters.
//
// Ports (mp_adder_arbiter):
//   iClk   in  1                   rising-edge clock
//   iRst   in  1                   asynchronous active-high reset
//   iReq   in  N_REQ               level request per requester, held until oGnt
//   iCmd   in  N_REQ               per-requester command, 0 = A+B, 1 = A-B
//   iOpA   in  N_REQ*OPERAND_WIDTH packed A operands, slice i belongs to requester i
//   iOpB   in  N_REQ*OPERAND_WIDTH packed B operands, same packing
//   oGnt   out N_REQ               one-cycle one-hot grant, operands captured on that edge
//   oDone  out N_REQ               one-cycle one-hot completion to the owner
//   oRes   out OPERAND_WIDTH+1     {carry, sum}; held until the next completion
//   oBusy  out 1                   high whenever the FSM is not IDLE
//
// Ports (mp_adder):
//   iClk, iRst                     as above
//   iStart   in  1                 load operands and begin (one-cycle pulse)
//   iCommand in  1                 0 = A+B, 1 = A+~B+1
//   iOpA/iOpB in OPERAND_WIDTH     operands, sampled with iStart
//   oDone    out 1                 one-cycle completion pulse
//   oRes     out OPERAND_WIDTH+1   {carry, sum}

module mp_adder #(
  parameter int OPERAND_WIDTH = 512,
  parameter int ADDER_WIDTH   = 128
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic                     iStart,
  input  logic                     iCommand,
  input  logic [OPERAND_WIDTH-1:0] iOpA,
  input  logic [OPERAND_WIDTH-1:0] iOpB,
  output logic                     oDone,
  output logic [OPERAND_WIDTH:0]   oRes
);
  localparam int NUM_WORDS = OPERAND_WIDTH / ADDER_WIDTH;
  localparam int CNT_W     = $clog2(NUM_WORDS);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_WORDS - 1);

  logic [OPERAND_WIDTH-1:0] a_reg;
  logic [OPERAND_WIDTH-1:0] b_reg;
  logic [OPERAND_WIDTH-1:0] sum_reg;
  logic                     carry_reg;
  logic                     run_reg;
  logic                     fin_reg;
  logic [CNT_W-1:0]         cnt_reg;
  logic [ADDER_WIDTH:0]     word_sum;

  // One word per cycle, least significant first. Operands shift down so the
  // adder always works on bits [ADDER_WIDTH-1:0]; results shift in at the top.
  assign word_sum = {1'b0, a_reg[ADDER_WIDTH-1:0]}
                  + {1'b0, b_reg[ADDER_WIDTH-1:0]}
                  + {{ADDER_WIDTH{1'b0}}, carry_reg};

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      run_reg   <= 1'b0;
      fin_reg   <= 1'b0;
      cnt_reg   <= '0;
      oDone     <= 1'b0;
      oRes      <= '0;
    end else begin
      fin_reg <= 1'b0;
      oDone   <= fin_reg;
      if (fin_reg) begin
        oRes <= {carry_reg, sum_reg};
      end
      if (iStart) begin
        a_reg     <= iOpA;
        // Subtraction as A + ~B + 1: the +1 enters as the initial carry.
        b_reg     <= iCommand ? ~iOpB : iOpB;
        carry_reg <= iCommand;
        cnt_reg   <= '0;
        run_reg   <= 1'b1;
      end else if (run_reg) begin
        sum_reg   <= {word_sum[ADDER_WIDTH-1:0], sum_reg[OPERAND_WIDTH-1:ADDER_WIDTH]};
        a_reg     <= a_reg >> ADDER_WIDTH;
        b_reg     <= b_reg >> ADDER_WIDTH;
        carry_reg <= word_sum[ADDER_WIDTH];
        cnt_reg   <= cnt_reg + 1'b1;
        if (cnt_reg == LAST_WORD) begin
          run_reg <= 1'b0;
          fin_reg <= 1'b1;
        end
      end
    end
  end
endmodule

module mp_adder_arbiter #(
  parameter int OPERAND_WIDTH = 512,
  parameter int ADDER_WIDTH   = 128,
  parameter int N_REQ         = 2
) (
  input  logic                           iClk,
  input  logic                           iRst,
  input  logic [N_REQ-1:0]               iReq,
  input  logic [N_REQ-1:0]               iCmd,
  input  logic [N_REQ*OPERAND_WIDTH-1:0] iOpA,
  input  logic [N_REQ*OPERAND_WIDTH-1:0] iOpB,
  output logic [N_REQ-1:0]               oGnt,
  output logic [N_REQ-1:0]               oDone,
  output logic [OPERAND_WIDTH:0]         oRes,
  output logic                           oBusy
);
  localparam int IDX_W = $clog2(N_REQ);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LAUNCH = 2'd1;
  localparam logic [1:0] BUSY   = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  logic [1:0]               state_reg;
  logic [IDX_W-1:0]         ptr_reg;
  logic [IDX_W-1:0]         owner_reg;
  logic [IDX_W-1:0]         next_owner;
  logic [IDX_W-1:0]         base_ptr;
  logic [IDX_W-1:0]         win_idx;
  logic                     win_found;
  logic [OPERAND_WIDTH-1:0] op_a_reg;
  logic [OPERAND_WIDTH-1:0] op_b_reg;
  logic                     cmd_reg;
  logic                     start_reg;
  logic                     add_done;
  logic [OPERAND_WIDTH:0]   add_res;

  logic [OPERAND_WIDTH-1:0] req_a [N_REQ];
  logic [OPERAND_WIDTH-1:0] req_b [N_REQ];

  // Unpack per-requester operands so only the winner's slice is ever selected;
  // X on losing slices cannot reach the captured registers.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
    assign req_a[gi] = iOpA[gi*OPERAND_WIDTH +: OPERAND_WIDTH];
    assign req_b[gi] = iOpB[gi*OPERAND_WIDTH +: OPERAND_WIDTH];
  end

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return IDX_W'(s);
  endfunction

  assign next_owner = (owner_reg == IDX_W'(N_REQ - 1)) ? '0 : owner_reg + 1'b1;

  // RESP also arbitrates so back-to-back service takes N+4 cycles. It uses
  // the pointer it is about to commit, which puts the just-served requester last.
  assign base_ptr = (state_reg == RESP) ? next_owner : ptr_reg;

  // Scan from the far end down so the nearest set bit after base_ptr wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (iReq[wrap_add(base_ptr, k)]) begin
        win_found = 1'b1;
        win_idx   = wrap_add(base_ptr, k);
      end
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      owner_reg <= '0;
      op_a_reg  <= '0;
      op_b_reg  <= '0;
      cmd_reg   <= 1'b0;
      start_reg <= 1'b0;
      oGnt      <= '0;
      oDone     <= '0;
      oRes      <= '0;
      oBusy     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, RESP: begin
          oDone <= '0;
          if (state_reg == RESP) begin
            ptr_reg <= next_owner;
          end
          if (win_found) begin
            op_a_reg  <= req_a[win_idx];
            op_b_reg  <= req_b[win_idx];
            cmd_reg   <= iCmd[win_idx];
            owner_reg <= win_idx;
            oGnt      <= N_REQ'(1) << win_idx;
            start_reg <= 1'b1;
            oBusy     <= 1'b1;
            state_reg <= LAUNCH;
          end else begin
            oBusy     <= 1'b0;
            state_reg <= IDLE;
          end
        end
        LAUNCH: begin
          oGnt      <= '0;
          start_reg <= 1'b0;
          state_reg <= BUSY;
        end
        BUSY: begin
          if (add_done) begin
            oRes      <= add_res;
            oDone     <= N_REQ'(1) << owner_reg;
            state_reg <= RESP;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  mp_adder #(
    .OPERAND_WIDTH(OPERAND_WIDTH),
    .ADDER_WIDTH  (ADDER_WIDTH)
  ) u_adder (
    .iClk    (iClk),
    .iRst    (iRst),
    .iStart  (start_reg),
    .iCommand(cmd_reg),
    .iOpA    (op_a_reg),
    .iOpB    (op_b_reg),
    .oDone   (add_done),
    .oRes    (add_res)
  );
endmodule

// File: tb/tb_mp_adder_arbiter.sv
// Testbench for mp_adder_arbiter. Two instances: the default configuration
// (2 requesters, 512/128) and a 4-requester 64/32 one for pointer wrap.
// Drivers push expected grants/results into queues; negedge monitors pop
// and compare whenever a grant or done strobe appears.

module tb_mp_adder_arbiter;
  localparam int OW    = 512;
  localparam int AW    = 128;
  localparam int NR    = 2;
  localparam int PER   = OW / AW + 4;
  localparam int DLAT  = OW / AW + 3;
  localparam int OW4   = 64;
  localparam int AW4   = 32;
  localparam int NR4   = 4;
  localparam int PER4  = OW4 / AW4 + 4;
  localparam int DLAT4 = OW4 / AW4 + 3;

  typedef logic [OW:0] res_t;
  typedef struct {
    int   owner;
    int   cyc;
    res_t res;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  logic [NR-1:0]    req, cmd, gnt, done;
  logic [NR*OW-1:0] opa, opb;
  logic [OW:0]      res;
  logic             busy;

  logic [NR4-1:0]     req4, cmd4, gnt4, done4;
  logic [NR4*OW4-1:0] opa4, opb4;
  logic [OW4:0]       res4;
  logic               busy4;

  int checks = 0;
  int errors = 0;

  exp_t gnt_q[$], done_q[$], gnt4_q[$], done4_q[$];

  // Reference model state: who is waiting, with which operands, and where the
  // round-robin search starts.
  logic [NR-1:0]   pend = '0;
  logic [OW-1:0]   pa[NR], pb[NR];
  logic            pc[NR];
  int              mptr = 0, last_g = -100, raise_cyc = 0;
  logic [NR4-1:0]  pend4 = '0;
  logic [OW4-1:0]  pa4[NR4], pb4[NR4];
  logic            pc4[NR4];
  int              mptr4 = 0, last_g4 = -100, raise4_cyc = 0;

  mp_adder_arbiter #(.OPERAND_WIDTH(OW), .ADDER_WIDTH(AW), .N_REQ(NR)) dut (
    .iClk(clk), .iRst(rst), .iReq(req), .iCmd(cmd), .iOpA(opa), .iOpB(opb),
    .oGnt(gnt), .oDone(done), .oRes(res), .oBusy(busy)
  );

  mp_adder_arbiter #(.OPERAND_WIDTH(OW4), .ADDER_WIDTH(AW4), .N_REQ(NR4)) dut4 (
    .iClk(clk), .iRst(rst), .iReq(req4), .iCmd(cmd4), .iOpA(opa4), .iOpB(opb4),
    .oGnt(gnt4), .oDone(done4), .oRes(res4), .oBusy(busy4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input res_t act, input res_t expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at cycle %0d actual=%h expected=%h", nm, cyc, act, expv);
    end
  endtask

  function automatic logic [OW-1:0] rnd_op();
    logic [OW-1:0] v;
    for (int k = 0; k < OW / 32; k++) v[k*32 +: 32] = $urandom;
    case ($urandom_range(0, 5))
      0: v = '1;
      1: v = '0;
      2: v = OW'(v[15:0]);
      default: ;
    endcase
    return v;
  endfunction

  // {carry, A+B} or {carry, A+~B+1}, straight from the arithmetic definition.
  function automatic res_t ref_op(input logic [OW-1:0] a, input logic [OW-1:0] b, input logic sub);
    if (sub) return {1'b0, a} + {1'b0, ~b} + res_t'(1);
    return {1'b0, a} + {1'b0, b};
  endfunction

  function automatic res_t ref_op4(input logic [OW4-1:0] a, input logic [OW4-1:0] b, input logic sub);
    logic [OW4:0] r;
    if (sub) r = {1'b0, a} + {1'b0, ~b} + (OW4+1)'(1);
    else     r = {1'b0, a} + {1'b0, b};
    return res_t'(r);
  endfunction

  task automatic raise(input int i, input logic [OW-1:0] a, input logic [OW-1:0] b, input logic c);
    pend[i] = 1'b1; pa[i] = a; pb[i] = b; pc[i] = c;
    opa[i*OW +: OW] = a; opb[i*OW +: OW] = b; cmd[i] = c; req[i] = 1'b1;
    raise_cyc = cyc;
  endtask

  task automatic raise4(input int i, input logic [OW4-1:0] a, input logic [OW4-1:0] b, input logic c);
    pend4[i] = 1'b1; pa4[i] = a; pb4[i] = b; pc4[i] = c;
    opa4[i*OW4 +: OW4] = a; opb4[i*OW4 +: OW4] = b; cmd4[i] = c; req4[i] = 1'b1;
    raise4_cyc = cyc;
  endtask

  // Requesters that are not waiting churn their inputs every cycle.
  task automatic scramble();
    for (int i = 0; i < NR; i++) begin
      if (!pend[i]) begin
        opa[i*OW +: OW] = rnd_op(); opb[i*OW +: OW] = rnd_op(); cmd[i] = 1'($urandom);
      end
    end
  endtask

  // Serve everything pending; returns at the negedge of the last RESP cycle.
  task automatic serve_all(input bit add_more);
    while (pend != '0) begin
      int w, tg;
      logic [NR-1:0] m;
      w = -1;
      for (int k = 0; k < NR; k++) if (w < 0 && pend[(mptr + k) % NR]) w = (mptr + k) % NR;
      tg = (last_g + PER > raise_cyc + 1) ? last_g + PER : raise_cyc + 1;
      gnt_q.push_back('{w, tg, res_t'(0)});
      done_q.push_back('{w, tg + DLAT, ref_op(pa[w], pb[w], pc[w])});
      while (cyc < tg) @(negedge clk);
      req[w] = 1'b0; pend[w] = 1'b0; mptr = (w + 1) % NR; last_g = tg;
      for (int t = tg; t < tg + PER - 1; t++) begin
        scramble();
        if (add_more && t == tg + 1) begin
          m = NR'($urandom);
          for (int i = 0; i < NR; i++) if (m[i] && !pend[i]) raise(i, rnd_op(), rnd_op(), 1'($urandom));
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic serve4();
    while (pend4 != '0) begin
      int w, tg;
      w = -1;
      for (int k = 0; k < NR4; k++) if (w < 0 && pend4[(mptr4 + k) % NR4]) w = (mptr4 + k) % NR4;
      tg = (last_g4 + PER4 > raise4_cyc + 1) ? last_g4 + PER4 : raise4_cyc + 1;
      gnt4_q.push_back('{w, tg, res_t'(0)});
      done4_q.push_back('{w, tg + DLAT4, ref_op4(pa4[w], pb4[w], pc4[w])});
      while (cyc < tg) @(negedge clk);
      req4[w] = 1'b0; pend4[w] = 1'b0; mptr4 = (w + 1) % NR4; last_g4 = tg;
      opa4[w*OW4 +: OW4] = '1; opb4[w*OW4 +: OW4] = '0; cmd4[w] = ~pc4[w];
      while (cyc < tg + PER4 - 1) @(negedge clk);
    end
  endtask

  // Scoreboard monitors.
  always @(negedge clk) begin
    exp_t e;
    if (gnt !== '0) begin
      if (gnt_q.size() == 0) chk("gnt_unexpected", res_t'(gnt), '0);
      else begin
        e = gnt_q.pop_front();
        chk("gnt_owner", res_t'(gnt), res_t'(1 << e.owner));
        chk("gnt_cycle", res_t'(cyc), res_t'(e.cyc));
      end
    end
    if (done !== '0) begin
      chk("gnt_during_done", res_t'(gnt), '0);
      if (done_q.size() == 0) chk("done_unexpected", res_t'(done), '0);
      else begin
        e = done_q.pop_front();
        chk("done_owner", res_t'(done), res_t'(1 << e.owner));
        chk("done_cycle", res_t'(cyc), res_t'(e.cyc));
        chk("done_res", res, e.res);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (gnt4 !== '0) begin
      if (gnt4_q.size() == 0) chk("gnt4_unexpected", res_t'(gnt4), '0);
      else begin
        e = gnt4_q.pop_front();
        chk("gnt4_owner", res_t'(gnt4), res_t'(1 << e.owner));
        chk("gnt4_cycle", res_t'(cyc), res_t'(e.cyc));
      end
    end
    if (done4 !== '0) begin
      if (done4_q.size() == 0) chk("done4_unexpected", res_t'(done4), '0);
      else begin
        e = done4_q.pop_front();
        chk("done4_owner", res_t'(done4), res_t'(1 << e.owner));
        chk("done4_cycle", res_t'(cyc), res_t'(e.cyc));
        chk("done4_res", res_t'(res4), e.res);
      end
    end
  end

  initial begin
    int tg, d;
    logic [NR-1:0] m;
    req = '0; cmd = '0; opa = '0; opb = '0;
    req4 = '0; cmd4 = '0; opa4 = '0; opb4 = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_gnt", res_t'(gnt), '0);
    chk("rst_done", res_t'(done), '0);
    chk("rst_res", res, '0);
    chk("rst_busy", res_t'(busy), '0);
    chk("rst4_res", res_t'(res4), '0);
    chk("rst4_busy", res_t'(busy4), '0);
    rst = 1'b0;
    @(negedge clk);

    // Single add with full carry-out, then oBusy timing.
    raise(0, '1, OW'(1), 1'b0);
    serve_all(1'b0);
    chk("busy_in_resp", res_t'(busy), res_t'(1));
    @(negedge clk);
    chk("busy_after_resp", res_t'(busy), '0);

    // Subtraction, both signs.
    raise(1, OW'(5), OW'(3), 1'b1);
    serve_all(1'b0);
    raise(1, OW'(3), OW'(5), 1'b1);
    serve_all(1'b0);

    // Both requesting, then both re-raising right on the last done.
    raise(0, rnd_op(), rnd_op(), 1'b0);
    raise(1, rnd_op(), rnd_op(), 1'b1);
    serve_all(1'b0);
    raise(0, rnd_op(), rnd_op(), 1'b1);
    raise(1, rnd_op(), rnd_op(), 1'b0);
    serve_all(1'b0);

    // Randomized rounds with mid-flight requests and operand churn.
    repeat (30) begin
      d = $urandom_range(0, 3);
      repeat (d) @(negedge clk);
      m = NR'($urandom_range(1, (1 << NR) - 1));
      for (int i = 0; i < NR; i++) if (m[i]) raise(i, rnd_op(), rnd_op(), 1'($urandom));
      serve_all(1'($urandom));
    end

    // Reset while BUSY: no done for the aborted operation.
    repeat (2) @(negedge clk);
    raise(0, rnd_op(), rnd_op(), 1'b0);
    tg = cyc + 1;
    gnt_q.push_back('{0, tg, res_t'(0)});
    while (cyc < tg) @(negedge clk);
    req[0] = 1'b0; pend[0] = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_gnt", res_t'(gnt), '0);
    chk("abort_done", res_t'(done), '0);
    chk("abort_res", res, '0);
    chk("abort_busy", res_t'(busy), '0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mptr = 0; last_g = -100; mptr4 = 0; last_g4 = -100;
    raise(1, rnd_op(), rnd_op(), 1'b1);
    serve_all(1'b0);

    // Four requesters: serve 3, then 0 and 3 together -> 0 first (wrap), then 3.
    raise4(3, OW4'(64'h1234_5678_9abc_def0), OW4'(64'hffff_0000_ffff_0000), 1'b0);
    serve4();
    @(negedge clk);
    raise4(0, '1, OW4'(1), 1'b0);
    raise4(3, OW4'(7), OW4'(9), 1'b1);
    serve4();
    repeat (6) begin
      @(negedge clk);
      for (int i = 0; i < NR4; i++) if ($urandom_range(0, 1) == 1) raise4(i, OW4'(rnd_op()), OW4'(rnd_op()), 1'($urandom));
      serve4();
    end

    repeat (12) @(negedge clk);
    chk("gnt_q_drained", res_t'(gnt_q.size() + gnt4_q.size()), '0);
    chk("done_q_drained", res_t'(done_q.size() + done4_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mp_adder_arbiter.md
# mp_adder_arbiter

Round-robin arbiter that shares one internally instantiated `mp_adder` between `N_REQ` requesters.
- It registers the winning requester's operands and command, and sequences the adder's start/done protocol.
- It returns the (OPERAND_WIDTH+1)-bit result to the winner with a one-cycle done strobe.
- It sits between the accelerator's client ports (e.g. the modular-arithmetic engines) and the shared multi-precision adder.

## Interface
- `OPERAND_WIDTH`, 512: operand width; passed to the adder.
- `ADDER_WIDTH`, 128: adder word width; `OPERAND_WIDTH/ADDER_WIDTH` must be an integer ≥ 2.
- `N_REQ`, 2: number of requesters, 2..8.
- `iClk` in 1: clock; all logic on the rising edge.
- `iRst` in 1: reset. One clock; reset is asynchronous and active-high. Must span at least one rising edge.
- `iReq` in N_REQ: request per requester. Level signal, held until `oGnt` for that requester.
- `iCmd` in N_REQ: per-requester command, 0 = A+B, 1 = A−B.
- `iOpA` in N_REQ*OPERAND_WIDTH: packed A operands; requester i occupies slice `[i*OPERAND_WIDTH +: OPERAND_WIDTH]`.
- `iOpB` in N_REQ*OPERAND_WIDTH: packed B operands, same packing as `iOpA`.
- `oGnt` out N_REQ: one-hot, one-cycle grant pulse. Operands were captured on the edge that raised it.
- `oDone` out N_REQ: one-hot, one-cycle completion pulse to the owner.
- `oRes` out OPERAND_WIDTH+1: result; valid while any `oDone` bit is high, held until the next completion.
- `oBusy` out 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, LAUNCH, BUSY, RESP. All outputs are registered.
- **IDLE**
  - If `iReq != 0`, pick the winner: the first set bit found searching upward from pointer `rPtr`, wrapping modulo N_REQ.
  - Register the winner's `iOpA`, `iOpB`, `iCmd` and index into `rOwner`.
  - Set `oGnt[winner]`, go to LAUNCH.
  - Otherwise stay in IDLE.
- **LAUNCH**
  - Drive adder `iStart=1` for exactly this cycle.
  - Clear `oGnt`, go to BUSY.
- **BUSY**
  - Adder `iStart=0`.
  - On the edge where adder `oDone=1`: capture adder `oRes` into `oRes`, set `oDone[rOwner]`, go to RESP.
- **RESP**
  - Clear `oDone`.
  - Set `rPtr = (rOwner+1) mod N_REQ`, go to IDLE.
- Adder `iOpA`, `iOpB` and `iCommand` are driven from the captured registers. They stay constant from LAUNCH through RESP; requester inputs may change freely after `oGnt`.
- Arithmetic:
  - Add: `oRes = {carry, A+B}`.
  - Subtract: `oRes = {carry, A+~B+1}`; MSB=1 means no borrow (A ≥ B).
- Requests are not queued. A requester whose `iReq` is low in IDLE loses nothing but is not remembered.
- A requester re-asserting `iReq` immediately after its own `oDone` gets lowest priority for that arbitration.
- **Reset** (any time, including mid-operation):
  - Outputs: `oGnt=0`, `oDone=0`, `oRes=0`, `oBusy=0`.
  - Internal: `rPtr=0`, FSM to IDLE, adder `iStart=0`.
  - The adder instance receives `iRst` and returns to its idle state. No `oDone` is issued for an aborted operation.
- Unused `iReq` bits beyond N_REQ do not exist; X on non-winning operand slices must not propagate.

## Timing
- Let N = OPERAND_WIDTH/ADDER_WIDTH. Adder contract: `iStart` sampled at edge E ⇒ adder `oDone` high in the cycle after edge E+N+1.
- Request sampled at edge e0 ⇒ `oGnt` high in cycle after e0.
- Adder `iStart` is high between e0 and e1.
- `oDone`/`oRes` valid in the cycle after e(N+3).
- `oBusy` falls after e(N+4).
- The earliest next request is sampled at e(N+4). Service period is N+4 cycles (8 for defaults).
- With continuous requests from all requesters, each requester is served at least once every N_REQ·(N+4) cycles.
- `oGnt` and `oDone` are never high in the same cycle.

## Test plan
1. **Single add.** Reset, then req0 with A=0xFFFF…F (512 ones), B=1, cmd=0 → `oGnt=01` after 1 cycle; `oDone=01` 7 cycles after request sampled; `oRes={1'b1, 512'h0}`; `oBusy` low 8 cycles after request.
2. **Subtraction, both signs.**
   - req1, A=5, B=3, cmd=1 → `oRes={1'b1, 512'd2}`, `oDone=10`.
   - Then A=3, B=5 → `oRes={1'b0, 2^512−2}`.
3. **Round-robin fairness.** `iReq=11` held continuously; each requester drops and re-raises `iReq` after its own `oDone` → grant order 0,1,0,1. Grants spaced exactly 8 cycles; each result returned to the correct owner.
4. **Operand isolation.** After `oGnt`, change the winner's `iOpA`/`iOpB`/`iCmd` every cycle → result reflects the values present at the grant edge only.
5. **Reset mid-operation.** Assert `iRst` asynchronously in BUSY (3 cycles after grant) → all outputs 0 immediately with no `oDone`. After release, req1 alone → served first, correct result.
6. **N_REQ=4, pointer wrap.** Serve requester 3, then `iReq=1001` → requester 0 granted next; then requester 3.
